// File: rtl/lsu_pkg.sv
// Shared encodings and lane helpers for the load/store unit.
package lsu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STATE_W = 3;

    // Request size encodings
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    // FSM state encodings
    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_RD   = 3'd1;
    localparam logic [STATE_W-1:0] ST_CAP  = 3'd2;
    localparam logic [STATE_W-1:0] ST_WR   = 3'd3;
    localparam logic [STATE_W-1:0] ST_RESP = 3'd4;

    // Pull the addressed lane out of a big-endian word and extend it.
    function automatic logic [DATA_W-1:0] lane_extract(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        off,
        input logic [1:0]        size,
        input logic              uns
    );
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            SIZE_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SIZE_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default:   r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane of a big-endian word with the low bits of wdata.
    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        off,
        input logic [1:0]        size,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] r;
        r = word;
        case (size)
            SIZE_BYTE: begin
                case (off)
                    2'd0:    r[31:24] = wdata[7:0];
                    2'd1:    r[23:16] = wdata[7:0];
                    2'd2:    r[15:8]  = wdata[7:0];
                    default: r[7:0]   = wdata[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (off[1]) r[15:0]  = wdata[15:0];
                else        r[31:16] = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane extraction (loads) and lane merge (sub-word stores).
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] word_i,
    input  logic [1:0]        offset_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] load_val_c_o,
    output logic [DATA_W-1:0] merge_word_c_o
);

    // Both results are pure functions of the captured memory word.
    always_comb begin
        load_val_c_o   = lane_extract(word_i, offset_i, size_i, unsigned_i);
        merge_word_c_o = lane_merge(word_i, offset_i, size_i, wdata_i);
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: word-aligns requests, sequences MR/MW, extracts
// and extends load lanes, and performs read-modify-write for sub-word stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_LIMIT = 40,
    parameter int unsigned RMW_ENABLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        MR,
    output logic        MW,
    output logic [31:0] add,
    output logic [31:0] wd,
    input  logic [31:0] data
);

    localparam logic RMW_ON = (RMW_ENABLE != 0);

    logic [STATE_W-1:0] state_q, state_d;
    logic               we_q, we_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [1:0]         off_q, off_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic               mr_q, mr_d;
    logic               mw_q, mw_d;
    logic [31:0]        add_q, add_d;
    logic [31:0]        wd_q, wd_d;

    logic [31:0]        aligned_c;
    logic               req_err_c;
    logic [31:0]        load_val_c;
    logic [31:0]        merge_word_c;

    lsu_lane_align u_align (
        .word_i         (data),
        .offset_i       (off_q),
        .size_i         (size_q),
        .unsigned_i     (uns_q),
        .wdata_i        (wdata_q),
        .load_val_c_o   (load_val_c),
        .merge_word_c_o (merge_word_c)
    );

    // Request legality: size, alignment, range and RMW availability.
    always_comb begin
        aligned_c = {req_addr[31:2], 2'b00};
        req_err_c = 1'b0;
        if (req_size == SIZE_BAD)                             req_err_c = 1'b1;
        if ((req_size == SIZE_HALF) && req_addr[0])           req_err_c = 1'b1;
        if ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00)) req_err_c = 1'b1;
        if (({1'b0, aligned_c} + 33'd3) > 33'(ADDR_LIMIT))    req_err_c = 1'b1;
        if (!RMW_ON && req_we && (req_size != SIZE_WORD))     req_err_c = 1'b1;
    end

    // Next-state and next-output logic; outputs follow the next state.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        add_d       = add_q;
        wd_d        = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                add_d = '0;
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata;
                    if (req_err_c) begin
                        state_d   = ST_RESP;
                        rsp_err_d = 1'b1;
                    end else if (req_we && (req_size == SIZE_WORD)) begin
                        state_d = ST_WR;
                        add_d   = aligned_c;
                        wd_d    = req_wdata;
                    end else begin
                        state_d = ST_RD;
                        add_d   = aligned_c;
                    end
                end
            end
            ST_RD: begin
                state_d = ST_CAP;
            end
            ST_CAP: begin
                if (we_q) begin
                    state_d = ST_WR;
                    wd_d    = merge_word_c;
                end else begin
                    state_d     = ST_RESP;
                    rsp_rdata_d = load_val_c;
                end
            end
            ST_WR: begin
                state_d = ST_RESP;
                add_d   = '0;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                add_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                add_d   = '0;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        mr_d        = (state_d == ST_RD);
        mw_d        = (state_d == ST_WR);
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            size_q      <= SIZE_BYTE;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mr_q        <= 1'b0;
            mw_q        <= 1'b0;
            add_q       <= '0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mr_q        <= mr_d;
            mw_q        <= mw_d;
            add_q       <= add_d;
            wd_q        <= wd_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign MR        = mr_q;
    assign MW        = mw_q;
    assign add       = add_q;
    assign wd        = wd_q;

endmodule
